// File: rtl/hnm_pkg.sv
// Shared HNM geometry, read latency and sequencer encodings.
// The widths and READ_LAT must match the HNMPP instance this sequencer drives.
package hnm_pkg;
    localparam int NROWS_HNM        = 128;
    localparam int NCOLS_HNM        = 128;
    localparam int ROWINDEXBITS_HNM = 7;
    localparam int COLINDEXBITS_HNM = 7;
    localparam int SSIDBITS         = ROWINDEXBITS_HNM + COLINDEXBITS_HNM;
    localparam int READ_LAT         = 2;
    localparam int HNM_CNTBITS      = 16;

    typedef logic [SSIDBITS-1:0]         ssid_t;
    typedef logic [ROWINDEXBITS_HNM-1:0] row_t;
    typedef logic [NCOLS_HNM-1:0]        rowdata_t;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_CLEAR_WAIT,
        ST_FILL,
        ST_LOOKUP,
        ST_DRAIN_L,
        ST_DUMP,
        ST_DRAIN_D,
        ST_DONE
    } seq_state_e;

    typedef enum logic {
        TAG_LKP,
        TAG_ROW
    } rd_tag_e;
endpackage

// File: rtl/hnm_rsp_tracker.sv
// Follows every HNMPP read for READ_LAT cycles and steers the returning data
// to the lookup-response or row-dump outputs according to the read's tag.
module hnm_rsp_tracker
    import hnm_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic     issue_lkp_i,
    input  logic     issue_row_i,
    input  ssid_t    ssid_passed_i,
    input  logic     hit_i,
    input  row_t     row_passed_i,
    input  rowdata_t row_data_i,
    output logic     rsp_valid_o,
    output ssid_t    rsp_ssid_o,
    output logic     rsp_hit_o,
    output logic     dump_valid_o,
    output row_t     dump_row_o,
    output rowdata_t dump_data_o,
    output logic     empty_o
);
    logic    [READ_LAT-1:0] vld_q;
    rd_tag_e                tag_q [READ_LAT];

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q <= '0;
            for (int i = 0; i < READ_LAT; i++) begin
                tag_q[i] <= TAG_LKP;
            end
        end else begin
            vld_q[0] <= issue_lkp_i | issue_row_i;
            tag_q[0] <= issue_row_i ? TAG_ROW : TAG_LKP;
            for (int i = 1; i < READ_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    // HNMPP data is only meaningful on the tracked cycle; zero it otherwise.
    assign rsp_valid_o  = vld_q[READ_LAT-1] && (tag_q[READ_LAT-1] == TAG_LKP);
    assign dump_valid_o = vld_q[READ_LAT-1] && (tag_q[READ_LAT-1] == TAG_ROW);
    assign rsp_ssid_o   = rsp_valid_o  ? ssid_passed_i : '0;
    assign rsp_hit_o    = rsp_valid_o  ? hit_i         : 1'b0;
    assign dump_row_o   = dump_valid_o ? row_passed_i  : '0;
    assign dump_data_o  = dump_valid_o ? row_data_i    : '0;

    // A read being issued this cycle counts as in flight.
    assign empty_o = ~(|vld_q) & ~issue_lkp_i & ~issue_row_i;
endmodule

// File: rtl/hnm_event_sequencer.sv
// Per-event HNMPP controller: clear, fill with hits, serve lookups, optional
// full-row dump. Sole driver of the HNMPP control inputs.
module hnm_event_sequencer
    import hnm_pkg::*;
#(
    parameter int CNTBITS = HNM_CNTBITS
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               evt_start,
    input  logic               dump_en,
    input  logic               hit_valid,
    output logic               hit_ready,
    input  ssid_t              hit_ssid,
    input  logic               hit_last,
    input  logic               lkp_valid,
    output logic               lkp_ready,
    input  ssid_t              lkp_ssid,
    input  logic               lkp_last,
    output logic               rsp_valid,
    output ssid_t              rsp_ssid,
    output logic               rsp_hit,
    output logic               dump_valid,
    output row_t               dump_row,
    output rowdata_t           dump_data,
    output logic               evt_done,
    output logic               busy,
    output logic [CNTBITS-1:0] hit_count,
    output logic               hit_ovf,
    output logic               hnm_reset,
    output logic               hnm_write,
    output ssid_t              hnm_SSID_write,
    input  logic               hnm_writeReady,
    output logic               hnm_read,
    output ssid_t              hnm_SSID_read,
    input  logic               hnm_readReady,
    output logic               hnm_readRow,
    output row_t               hnm_rowRead,
    input  logic               hnm_busy,
    input  ssid_t              hnm_SSID_passed,
    input  logic               hnm_HNM_readOutput,
    input  row_t               hnm_rowPassed,
    input  rowdata_t           hnm_rowReadOutput
);
    seq_state_e         state_q, state_d;
    logic               dump_q, dump_d;
    logic [CNTBITS-1:0] cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    row_t               row_q, row_d;
    logic               wr_q, wr_d;
    ssid_t              wr_ssid_q, wr_ssid_d;
    logic               rd_q, rd_d;
    ssid_t              rd_ssid_q, rd_ssid_d;
    logic               hit_acc, lkp_acc, trk_empty;

    assign hit_ready = (state_q == ST_FILL)   && hnm_writeReady;
    assign lkp_ready = (state_q == ST_LOOKUP) && hnm_readReady;
    assign hit_acc   = hit_valid && hit_ready;
    assign lkp_acc   = lkp_valid && lkp_ready;

    always_comb begin
        state_d   = state_q;
        dump_d    = dump_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        row_d     = row_q;
        wr_d      = hit_acc;
        wr_ssid_d = hit_acc ? hit_ssid : '0;
        rd_d      = lkp_acc;
        rd_ssid_d = lkp_acc ? lkp_ssid : '0;
        unique case (state_q)
            ST_IDLE: begin
                if (evt_start) begin
                    state_d = ST_CLEAR;
                    dump_d  = dump_en;
                end
            end
            ST_CLEAR: begin
                state_d = ST_CLEAR_WAIT;
                cnt_d   = '0;
                ovf_d   = 1'b0;
            end
            ST_CLEAR_WAIT: begin
                if (!hnm_busy) state_d = ST_FILL;
            end
            ST_FILL: begin
                if (hit_acc) begin
                    if (&cnt_q) ovf_d = 1'b1;
                    else        cnt_d = cnt_q + CNTBITS'(1);
                    if (hit_last) state_d = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                if (lkp_acc && lkp_last) state_d = ST_DRAIN_L;
            end
            ST_DRAIN_L: begin
                if (trk_empty) state_d = dump_q ? ST_DUMP : ST_DONE;
            end
            ST_DUMP: begin
                // One row read per cycle; counter returns to 0 for the next event.
                if (row_q == row_t'(NROWS_HNM - 1)) begin
                    row_d   = '0;
                    state_d = ST_DRAIN_D;
                end else begin
                    row_d = row_q + row_t'(1);
                end
            end
            ST_DRAIN_D: begin
                if (trk_empty) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            dump_q    <= 1'b0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            row_q     <= '0;
            wr_q      <= 1'b0;
            wr_ssid_q <= '0;
            rd_q      <= 1'b0;
            rd_ssid_q <= '0;
        end else begin
            state_q   <= state_d;
            dump_q    <= dump_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            row_q     <= row_d;
            wr_q      <= wr_d;
            wr_ssid_q <= wr_ssid_d;
            rd_q      <= rd_d;
            rd_ssid_q <= rd_ssid_d;
        end
    end

    assign hnm_reset      = (state_q == ST_CLEAR);
    assign hnm_write      = wr_q;
    assign hnm_SSID_write = wr_ssid_q;
    assign hnm_read       = rd_q;
    assign hnm_SSID_read  = rd_ssid_q;
    assign hnm_readRow    = (state_q == ST_DUMP);
    assign hnm_rowRead    = (state_q == ST_DUMP) ? row_q : '0;
    assign evt_done       = (state_q == ST_DONE);
    assign busy           = (state_q != ST_IDLE);
    assign hit_count      = cnt_q;
    assign hit_ovf        = ovf_q;

    hnm_rsp_tracker u_trk (
        .clk          (clk),
        .reset        (reset),
        .issue_lkp_i  (rd_q),
        .issue_row_i  (hnm_readRow),
        .ssid_passed_i(hnm_SSID_passed),
        .hit_i        (hnm_HNM_readOutput),
        .row_passed_i (hnm_rowPassed),
        .row_data_i   (hnm_rowReadOutput),
        .rsp_valid_o  (rsp_valid),
        .rsp_ssid_o   (rsp_ssid),
        .rsp_hit_o    (rsp_hit),
        .dump_valid_o (dump_valid),
        .dump_row_o   (dump_row),
        .dump_data_o  (dump_data),
        .empty_o      (trk_empty)
    );
endmodule

// File: tb/tb_hnm_event_sequencer.sv
// Directed/randomized bench: behavioural HNMPP plus a set-based reference of
// the event contents, checked with immediate assertions.
module tb_hnm_event_sequencer;
    import hnm_pkg::*;

    localparam int CNTB  = 4;
    localparam int CMAX  = (1 << CNTB) - 1;
    localparam int LIMIT = 2000;

    logic clk = 1'b0;
    logic reset, evt_start, dump_en;
    logic hit_valid, hit_ready, hit_last, lkp_valid, lkp_ready, lkp_last;
    ssid_t hit_ssid, lkp_ssid, rsp_ssid;
    logic rsp_valid, rsp_hit, dump_valid, evt_done, busy, hit_ovf;
    row_t dump_row;
    rowdata_t dump_data;
    logic [CNTB-1:0] hit_count;
    logic hnm_reset, hnm_write, hnm_writeReady, hnm_read, hnm_readReady, hnm_readRow, hnm_busy;
    ssid_t hnm_SSID_write, hnm_SSID_read, hnm_SSID_passed;
    logic hnm_HNM_readOutput;
    row_t hnm_rowRead, hnm_rowPassed;
    rowdata_t hnm_rowReadOutput;

    always #5 clk = ~clk;

    hnm_event_sequencer #(.CNTBITS(CNTB)) dut (
        .clk(clk), .reset(reset), .evt_start(evt_start), .dump_en(dump_en),
        .hit_valid(hit_valid), .hit_ready(hit_ready), .hit_ssid(hit_ssid), .hit_last(hit_last),
        .lkp_valid(lkp_valid), .lkp_ready(lkp_ready), .lkp_ssid(lkp_ssid), .lkp_last(lkp_last),
        .rsp_valid(rsp_valid), .rsp_ssid(rsp_ssid), .rsp_hit(rsp_hit),
        .dump_valid(dump_valid), .dump_row(dump_row), .dump_data(dump_data),
        .evt_done(evt_done), .busy(busy), .hit_count(hit_count), .hit_ovf(hit_ovf),
        .hnm_reset(hnm_reset), .hnm_write(hnm_write), .hnm_SSID_write(hnm_SSID_write),
        .hnm_writeReady(hnm_writeReady), .hnm_read(hnm_read), .hnm_SSID_read(hnm_SSID_read),
        .hnm_readReady(hnm_readReady), .hnm_readRow(hnm_readRow), .hnm_rowRead(hnm_rowRead),
        .hnm_busy(hnm_busy), .hnm_SSID_passed(hnm_SSID_passed),
        .hnm_HNM_readOutput(hnm_HNM_readOutput), .hnm_rowPassed(hnm_rowPassed),
        .hnm_rowReadOutput(hnm_rowReadOutput)
    );

    // Behavioural HNMPP: bit map, random clear time, fixed read latency.
    logic [NROWS_HNM-1:0][NCOLS_HNM-1:0] mem;
    int unsigned busy_cnt = 0;
    ssid_t    p_ssid [READ_LAT];
    logic     p_hit  [READ_LAT];
    row_t     p_row  [READ_LAT];
    rowdata_t p_data [READ_LAT];

    always @(posedge clk) begin
        if (hnm_reset) begin
            mem      <= '0;
            busy_cnt <= $urandom_range(1, 4);
        end else begin
            if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
            if (hnm_write) mem[hnm_SSID_write[SSIDBITS-1:COLINDEXBITS_HNM]][hnm_SSID_write[COLINDEXBITS_HNM-1:0]] <= 1'b1;
        end
        p_ssid[0] <= hnm_SSID_read;
        p_hit[0]  <= mem[hnm_SSID_read[SSIDBITS-1:COLINDEXBITS_HNM]][hnm_SSID_read[COLINDEXBITS_HNM-1:0]];
        p_row[0]  <= hnm_rowRead;
        p_data[0] <= mem[hnm_rowRead];
        for (int i = 1; i < READ_LAT; i++) begin
            p_ssid[i] <= p_ssid[i-1];
            p_hit[i]  <= p_hit[i-1];
            p_row[i]  <= p_row[i-1];
            p_data[i] <= p_data[i-1];
        end
    end
    assign hnm_busy           = (busy_cnt != 0);
    assign hnm_SSID_passed    = p_ssid[READ_LAT-1];
    assign hnm_HNM_readOutput = p_hit[READ_LAT-1];
    assign hnm_rowPassed      = p_row[READ_LAT-1];
    assign hnm_rowReadOutput  = p_data[READ_LAT-1];

    // Reference state for the current event.
    typedef struct { int ssid; bit hit; } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;
    int   ev_hits[$];
    bit   ref_map[int];
    int   hit_list[$], lkp_list[$];
    int   ev_done, ev_dumps, dump_nxt;
    int   n_cmp = 0, n_err = 0;
    logic [READ_LAT-1:0] rd_hist = '0, row_hist = '0;
    rowdata_t exp_row;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (hnm_write || hnm_read) chk("wr_rd_excl", 128'(hnm_write & hnm_read), 128'(0));
        if (evt_done) ev_done++;
        if (rsp_valid) begin
            chk("rsp_latency", 128'(rd_hist[READ_LAT-1]), 128'(1));
            if (exp_q.size() == 0) begin
                chk("rsp_spurious", 128'(rsp_valid), 128'(0));
            end else begin
                mon_e = exp_q.pop_front();
                chk("rsp_ssid", 128'(rsp_ssid), 128'(mon_e.ssid));
                chk("rsp_hit", 128'(rsp_hit), 128'(mon_e.hit));
            end
        end
        if (dump_valid) begin
            exp_row = '0;
            foreach (ev_hits[k])
                if (ev_hits[k] / NCOLS_HNM == dump_nxt) exp_row[ev_hits[k] % NCOLS_HNM] = 1'b1;
            chk("dump_latency", 128'(row_hist[READ_LAT-1]), 128'(1));
            chk("dump_row", 128'(dump_row), 128'(dump_nxt));
            chk("dump_data", 128'(dump_data), 128'(exp_row));
            dump_nxt++;
            ev_dumps++;
        end
        rd_hist  = {rd_hist[READ_LAT-2:0], hnm_read};
        row_hist = {row_hist[READ_LAT-2:0], hnm_readRow};
    end

    task automatic make_lists(input int nh, input int nl);
        hit_list.delete();
        lkp_list.delete();
        for (int k = 0; k < nh; k++) hit_list.push_back(int'($urandom_range(0, 16383)));
        for (int k = 0; k < nl; k++)
            lkp_list.push_back($urandom_range(0, 1) ? hit_list[$urandom_range(0, nh - 1)]
                                                    : int'($urandom_range(0, 16383)));
    endtask

    task automatic run_event(input bit dmp, input bit stall, input bit poke, input bit rst_mid);
        int i, guard, stall_left, exp_cnt;
        bit stalled;
        exp_t e;
        ev_hits.delete();
        ref_map.delete();
        ev_done = 0; ev_dumps = 0; dump_nxt = 0;
        @(negedge clk);
        evt_start = 1'b1; dump_en = dmp;
        @(negedge clk);
        evt_start = 1'b0; dump_en = 1'b0;
        chk("clear_pulse", 128'(hnm_reset), 128'(1));
        chk("busy_set", 128'(busy), 128'(1));
        @(negedge clk);
        chk("clear_once", 128'(hnm_reset), 128'(0));
        i = 0; guard = 0; stall_left = 0; stalled = 0;
        while (i < hit_list.size() && guard < LIMIT) begin
            guard++;
            if (stall && i == 2 && !stalled) begin stalled = 1; stall_left = 5; end
            hnm_writeReady = (stall_left > 0) ? 1'b0 : ($urandom_range(0, 3) != 0);
            hit_valid = 1'b1;
            hit_ssid  = SSIDBITS'(hit_list[i]);
            hit_last  = (i == hit_list.size() - 1);
            lkp_valid = 1'($urandom_range(0, 1));
            lkp_ssid  = SSIDBITS'($urandom_range(0, 16383));
            evt_start = poke && i == 3;
            #1;
            if (lkp_valid) chk("lkp_rdy_fill", 128'(lkp_ready), 128'(0));
            if (stall_left > 0) begin
                chk("stall_hit_rdy", 128'(hit_ready), 128'(0));
                if (stall_left < 5) chk("stall_no_write", 128'(hnm_write), 128'(0));
                stall_left--;
            end
            if (hit_ready) begin
                ev_hits.push_back(hit_list[i]);
                ref_map[hit_list[i]] = 1'b1;
                i++;
            end
            @(negedge clk);
        end
        chk("fill_bound", 128'(guard < LIMIT), 128'(1));
        hit_valid = 1'b0; hit_last = 1'b0; lkp_valid = 1'b0; evt_start = 1'b0; hnm_writeReady = 1'b1;
        i = 0; guard = 0;
        while (i < lkp_list.size() && guard < LIMIT) begin
            guard++;
            hnm_readReady = ($urandom_range(0, 3) != 0);
            lkp_valid = 1'b1;
            lkp_ssid  = SSIDBITS'(lkp_list[i]);
            lkp_last  = (i == lkp_list.size() - 1);
            hit_valid = 1'($urandom_range(0, 1));
            hit_ssid  = SSIDBITS'($urandom_range(0, 16383));
            #1;
            if (hit_valid) chk("hit_rdy_lkp", 128'(hit_ready), 128'(0));
            if (lkp_ready) begin
                e.ssid = lkp_list[i];
                e.hit  = ref_map.exists(lkp_list[i]) != 0;
                exp_q.push_back(e);
                i++;
            end
            @(negedge clk);
        end
        chk("lkp_bound", 128'(guard < LIMIT), 128'(1));
        lkp_valid = 1'b0; lkp_last = 1'b0; hit_valid = 1'b0; hnm_readReady = 1'b1;
        if (rst_mid) begin
            #2;
            reset = 1'b1;
            exp_q.delete();
            @(negedge clk);
            chk("rst_idle", 128'(busy), 128'(0));
            chk("rst_hnm_ctl", 128'({hnm_reset, hnm_write, hnm_read, hnm_readRow}), 128'(0));
            chk("rst_hnm_addr", 128'({hnm_SSID_write, hnm_SSID_read, hnm_rowRead}), 128'(0));
            chk("rst_outs", 128'({rsp_valid, dump_valid, evt_done, hit_ready, lkp_ready}), 128'(0));
            chk("rst_cnt", 128'({hit_ovf, hit_count}), 128'(0));
            reset = 1'b0;
            repeat (6) @(negedge clk);
            chk("rst_stay_idle", 128'(busy), 128'(0));
            return;
        end
        guard = 0;
        while (busy && guard < LIMIT) begin guard++; @(negedge clk); end
        chk("done_bound", 128'(guard < LIMIT), 128'(1));
        exp_cnt = (ev_hits.size() > CMAX) ? CMAX : ev_hits.size();
        chk("evt_done_once", 128'(ev_done), 128'(1));
        chk("rsp_all_seen", 128'(exp_q.size()), 128'(0));
        chk("dump_count", 128'(ev_dumps), 128'(dmp ? NROWS_HNM : 0));
        chk("hit_count", 128'(hit_count), 128'(exp_cnt));
        chk("hit_ovf", 128'(hit_ovf), 128'(ev_hits.size() > CMAX));
        repeat (3) @(negedge clk);
        chk("idle_hold", 128'({busy, hit_count}), 128'(exp_cnt));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish within budget");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; evt_start = 1'b0; dump_en = 1'b0;
        hit_valid = 1'b0; hit_ssid = '0; hit_last = 1'b0;
        lkp_valid = 1'b0; lkp_ssid = '0; lkp_last = 1'b0;
        hnm_writeReady = 1'b1; hnm_readReady = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_busy", 128'(busy), 128'(0));
        chk("reset_hnm", 128'({hnm_reset, hnm_write, hnm_read, hnm_readRow}), 128'(0));
        chk("reset_outs", 128'({rsp_valid, dump_valid, evt_done, hit_ready, lkp_ready, hit_ovf, hit_count}), 128'(0));
        reset = 1'b0;
        @(negedge clk);

        hit_list = '{32'h404, 32'h208, 32'h2C7};
        lkp_list = '{32'h404, 32'h405};
        run_event(1'b0, 1'b0, 1'b0, 1'b0);

        // Second event: 0x404 from the previous event must be gone.
        hit_list = '{32'h080};
        lkp_list = '{32'h080, 32'h404};
        run_event(1'b1, 1'b0, 1'b0, 1'b0);

        make_lists(8, 6);
        run_event(1'b0, 1'b1, 1'b0, 1'b0);

        make_lists(17, 5);
        run_event(1'b1, 1'b0, 1'b1, 1'b0);

        for (int ev = 0; ev < 3; ev++) begin
            make_lists($urandom_range(1, 20), $urandom_range(1, 12));
            run_event(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
        end

        make_lists(6, 6);
        run_event(1'b0, 1'b0, 1'b0, 1'b1);

        make_lists(5, 5);
        run_event(1'b0, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
